// File: rtl/bram_sdp_4p_rd_arb.sv
// rtl/bram_sdp_4p_rd_arb.sv - round-robin arbiter sharing a 4-word SDP BRAM read port among NREQ requesters
module bram_sdp_4p_rd_arb #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int NREQ  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NREQ-1:0]                  req_valid,
    input  logic [NREQ*$clog2(DEPTH)-1:0]    req_addr,
    output logic [NREQ-1:0]                  req_ready,
    output logic [$clog2(DEPTH)-1:0]         bram_addr,
    input  logic [4*WIDTH-1:0]               bram_data,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [4*WIDTH-1:0]               rsp_data,
    output logic [$clog2(NREQ)-1:0]          rsp_id
);
    localparam int ADDRW = $clog2(DEPTH);
    localparam int IDW   = $clog2(NREQ);

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     id_q;
    logic [IDW-1:0]     win;
    logic               found;
    logic               grant;
    logic               run_q;
    logic               inflight;
    logic [1:0]         count;
    logic [2:0]         occ;
    logic               issue_ok;
    logic               pop;
    logic [ADDRW-1:0]   addr_q;
    logic [ADDRW-1:0]   sel_addr;
    logic [4*WIDTH-1:0] fifo_data [2];
    logic [IDW-1:0]     fifo_id   [2];
    logic               rd_ptr;
    logic               wr_ptr;

    assign rsp_valid = (count != 2'd0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = fifo_data[rd_ptr];
    assign rsp_id    = fifo_id[rd_ptr];

    // Slots already promised (held + landing next cycle) must leave room for one more read.
    assign occ      = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue_ok = (occ <= 3'd1);

    // First pass covers indices at/above the pointer, second pass wraps to the lowest index.
    always_comb begin
        found    = 1'b0;
        win      = ptr;
        sel_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (IDW'(i) >= ptr)) begin
                found    = 1'b1;
                win      = IDW'(i);
                sel_addr = req_addr[i*ADDRW +: ADDRW];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i]) begin
                found    = 1'b1;
                win      = IDW'(i);
                sel_addr = req_addr[i*ADDRW +: ADDRW];
            end
        end
    end

    // run_q keeps req_ready low while reset is asserted and for the release cycle.
    assign grant     = found & issue_ok & run_q;
    assign req_ready = grant ? (NREQ'(1) << win) : '0;
    assign bram_addr = grant ? sel_addr : addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            ptr          <= '0;
            id_q         <= '0;
            inflight     <= 1'b0;
            count        <= 2'd0;
            addr_q       <= '0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_id[0]   <= '0;
            fifo_id[1]   <= '0;
        end else begin
            run_q    <= 1'b1;
            inflight <= grant;
            if (grant) begin
                ptr    <= (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
                id_q   <= win;
                addr_q <= sel_addr;
            end
            if (inflight) begin
                fifo_data[wr_ptr] <= bram_data;
                fifo_id[wr_ptr]   <= id_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_bram_sdp_4p_rd_arb.sv
// tb/tb_bram_sdp_4p_rd_arb.sv - scoreboard bench for bram_sdp_4p_rd_arb
module tb_bram_sdp_4p_rd_arb;
    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int NREQ  = 4;
    localparam int ADDRW = 8;
    localparam int IDW   = 2;

    logic                    clk;
    logic                    rst_n;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*ADDRW-1:0]   req_addr;
    logic [NREQ-1:0]         req_ready;
    logic [ADDRW-1:0]        bram_addr;
    logic [4*WIDTH-1:0]      bram_data;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [4*WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]          rsp_id;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    data;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem [DEPTH];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          cyc      = 0;
    int          rsp_cnt  = 0;

    bram_sdp_4p_rd_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .bram_addr (bram_addr),
        .bram_data (bram_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        bram_data <= {mem[bram_addr + 8'd3], mem[bram_addr + 8'd2], mem[bram_addr + 8'd1], mem[bram_addr]};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_word(input logic [7:0] a);
        logic [31:0] r;
        logic [7:0]  b;
        for (int k = 0; k < 4; k++) begin
            b = a + 8'(k);
            r[k*8 +: 8] = mem[b];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                rsp_cnt++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    e.id   = IDW'(i);
                    e.data = exp_word(req_addr[i*ADDRW +: ADDRW]);
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        sb.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic single(input int id, input logic [7:0] a, input string tag);
        bit got;
        got = 0;
        req_addr[id*ADDRW +: ADDRW] = a;
        req_valid[id] = 1'b1;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1;
        end
        check({tag, "_accept"}, 64'(got), 64'd1);
        step();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        bit got;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        check({tag, "_rsp_seen"}, 64'(got), 64'd1);
    endtask

    task automatic drain(input string tag);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();
        check({tag, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int ta, n_acc, grants;
        bit hit;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ta, n_acc, grants, r0;
        bit hit;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 3));
        mem[8'h10] = 8'hA0; mem[8'h11] = 8'hA1; mem[8'h12] = 8'hA2; mem[8'h13] = 8'hA3;

        rst_n = 1'b0; req_valid = '0; req_addr = '0; rsp_ready = 1'b0;
        #3;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data",  64'(rsp_data),  64'd0);
        check("rst_rsp_id",    64'(rsp_id),    64'd0);
        check("rst_bram_addr", 64'(bram_addr), 64'd0);
        do_reset();

        // single request, latency 2
        rsp_ready = 1'b1;
        req_addr[7:0] = 8'h10;
        req_valid[0] = 1'b1;
        hit = 0; ta = 0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (req_ready[0]) begin hit = 1; ta = cyc; end
        end
        check("t1_accept", 64'(hit), 64'd1);
        step();
        req_valid[0] = 1'b0;
        wait_rsp("t1");
        check("t1_latency", 64'(cyc - ta), 64'd2);
        check("t1_data", 64'(rsp_data), 64'hA3A2A1A0);
        check("t1_id", 64'(rsp_id), 64'd0);
        drain("t1");

        // contention: round robin, one grant per cycle
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) req_addr[i*ADDRW +: ADDRW] = 8'(i * 32 + 5);
        req_valid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("cont_grant", 64'(req_ready), 64'd1 << (k % 4));
        end
        step();
        drain("cont");

        // backpressure: two outstanding, then stall
        do_reset();
        rsp_ready = 1'b0;
        req_addr[1*ADDRW +: ADDRW] = 8'h40;
        req_valid[1] = 1'b1;
        n_acc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            hit = req_ready[1];
            if (hit) n_acc++;
            step();
            if (hit) req_addr[1*ADDRW +: ADDRW] = req_addr[1*ADDRW +: ADDRW] + 8'd4;
        end
        @(negedge clk);
        check("bp_accepts", 64'(n_acc), 64'd2);
        check("bp_ready_low", 64'(req_ready), 64'd0);
        check("bp_hold_data", 64'(rsp_data), 64'(exp_word(8'h40)));
        @(negedge clk);
        check("bp_hold_data2", 64'(rsp_data), 64'(exp_word(8'h40)));
        check("bp_hold_id", 64'(rsp_id), 64'd1);
        r0 = rsp_cnt;
        drain("bp");
        check("bp_returned", 64'(rsp_cnt - r0), 64'd2);

        // address wrap
        rsp_ready = 1'b1;
        single(3, 8'hFE, "wrap");
        wait_rsp("wrap");
        check("wrap_data", 64'(rsp_data), 64'({mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]}));
        check("wrap_id", 64'(rsp_id), 64'd3);
        drain("wrap");

        // fairness
        do_reset();
        rsp_ready = 1'b1;
        req_addr[0*ADDRW +: ADDRW] = 8'h20;
        req_valid[0] = 1'b1;
        step();
        step();
        req_addr[2*ADDRW +: ADDRW] = 8'h80;
        req_valid[2] = 1'b1;
        grants = 0; hit = 0;
        for (int k = 0; k < 8 && !hit; k++) begin
            @(negedge clk);
            if (req_ready != '0) grants++;
            if (req_ready[2]) hit = 1;
        end
        check("fair_hit", 64'(hit), 64'd1);
        check("fair_within", 64'(grants <= 2), 64'd1);
        step();
        req_valid[2] = 1'b0;
        req_addr[3*ADDRW +: ADDRW] = 8'h90;
        req_valid[3] = 1'b1;
        @(negedge clk);
        check("fair_ptr", 64'(req_ready), 64'b1000);
        step();
        drain("fair");

        // reset with response held and read inflight
        do_reset();
        rsp_ready = 1'b0;
        req_addr[1*ADDRW +: ADDRW] = 8'h50;
        req_valid[1] = 1'b1;
        step();
        step();
        check("rst_pre_valid", 64'(rsp_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_valid", 64'(rsp_valid), 64'd0);
        check("rst_mid_data",  64'(rsp_data),  64'd0);
        check("rst_mid_id",    64'(rsp_id),    64'd0);
        check("rst_mid_ready", 64'(req_ready), 64'd0);
        check("rst_mid_addr",  64'(bram_addr), 64'd0);
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_no_stale", 64'(rsp_valid), 64'd0);
        end
        step();
        req_addr[2*ADDRW +: ADDRW] = 8'h60;
        req_addr[3*ADDRW +: ADDRW] = 8'h70;
        req_valid = 4'b1100;
        @(negedge clk);
        check("rst_first_grant", 64'(req_ready), 64'b0100);
        step();
        drain("rst");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
